// File: rtl/semaforo_pkg.sv
// Shared types and constants for the two-road phase scheduler.
// Lamp encodings are one-hot: bit2 vermelho, bit1 amarelo, bit0 verde.
package semaforo_pkg;

    typedef enum logic [2:0] {
        A_VERDE,
        A_AMARELO,
        VERM_A,
        B_VERDE,
        B_AMARELO,
        VERM_B,
        PED
    } state_t;

    typedef enum logic {
        ROAD_A,
        ROAD_B
    } road_t;

    localparam logic [2:0] LAMP_VERDE    = 3'b001;
    localparam logic [2:0] LAMP_AMARELO  = 3'b010;
    localparam logic [2:0] LAMP_VERMELHO = 3'b100;

    localparam logic [7:0] VERDE     = 8'd3;
    localparam logic [7:0] VERDE_MAX = 8'd8;
    localparam logic [7:0] AMARELO   = 8'd1;
    localparam logic [7:0] VERMELHO  = 8'd2;
    localparam logic [7:0] WALK      = 8'd4;

    // Packed {A, B} head lamps for a given phase.
    function automatic logic [5:0] lamps(state_t s);
        unique case (s)
            A_VERDE:   return {LAMP_VERDE, LAMP_VERMELHO};
            A_AMARELO: return {LAMP_AMARELO, LAMP_VERMELHO};
            B_VERDE:   return {LAMP_VERMELHO, LAMP_VERDE};
            B_AMARELO: return {LAMP_VERMELHO, LAMP_AMARELO};
            default:   return {LAMP_VERMELHO, LAMP_VERMELHO};
        endcase
    endfunction

endpackage

// File: rtl/semaforo_escalonador_if.sv
// Sensor inputs and lamp outputs of the phase scheduler.
// The scheduler sits on the slave side.
interface semaforo_escalonador_if;
    logic       bt;
    logic       req_a;
    logic       req_b;
    logic [2:0] A;
    logic [2:0] B;
    logic       ped_walk;

    modport master (
        output bt, req_a, req_b,
        input  A, B, ped_walk
    );

    modport slave (
        input  bt, req_a, req_b,
        output A, B, ped_walk
    );
endinterface

// File: rtl/semaforo_timer.sv
// Shared phase timer: 8-bit saturating count, cleared on phase change.
// o_done flags the last cycle of a phase lasting i_t cycles.
module semaforo_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic [7:0] i_t,
    output logic [7:0] o_cnt,
    output logic       o_done
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = (r_cnt == i_t - 8'd1);
endmodule

// File: rtl/semaforo_escalonador.sv
// Demand-driven phase scheduler for two roads and a pedestrian crossing.
// Lamps are registered from the next state, so they track the state register.
module semaforo_escalonador
    import semaforo_pkg::*;
#(
    parameter logic [7:0] T_VERDE_MIN = VERDE,
    parameter logic [7:0] T_VERDE_MAX = VERDE_MAX,
    parameter logic [7:0] T_AMARELO   = AMARELO,
    parameter logic [7:0] T_VERMELHO  = VERMELHO,
    parameter logic [7:0] T_PED       = WALK
) (
    input  logic                         clk,
    input  logic                         rst,
    semaforo_escalonador_if.slave        bus
);
    state_t     r_state;
    state_t     w_next;
    road_t      r_nxt;
    logic       r_pend_a;
    logic       r_pend_b;
    logic       r_ped_pend;
    logic [2:0] r_a;
    logic [2:0] r_b;
    logic       r_walk;

    logic [7:0] w_t;
    logic [7:0] w_cnt;
    logic       w_done;
    logic       w_chg;
    logic [8:0] w_elapsed;
    logic       w_min;
    logic       w_max;

    assign w_elapsed = {1'b0, w_cnt} + 9'd1;
    assign w_min     = w_elapsed >= {1'b0, T_VERDE_MIN};
    assign w_max     = w_elapsed >= {1'b0, T_VERDE_MAX};
    assign w_chg     = (w_next != r_state);

    always_comb begin
        w_t = T_VERDE_MIN;
        unique case (r_state)
            A_AMARELO, B_AMARELO: w_t = T_AMARELO;
            VERM_A, VERM_B:       w_t = T_VERMELHO;
            PED:                  w_t = T_PED;
            default:              w_t = T_VERDE_MIN;
        endcase
    end

    semaforo_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_chg),
        .i_t    (w_t),
        .o_cnt  (w_cnt),
        .o_done (w_done)
    );

    // Green is held while its own road keeps asking, up to the max.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            A_VERDE:
                if (w_min && (r_pend_b || r_ped_pend)
                    && (!bus.req_a || w_max))
                    w_next = A_AMARELO;
            A_AMARELO:
                if (w_done) w_next = VERM_A;
            VERM_A:
                if (w_done) w_next = r_ped_pend ? PED : B_VERDE;
            B_VERDE:
                if (w_min && (r_pend_a || r_ped_pend)
                    && (!bus.req_b || w_max))
                    w_next = B_AMARELO;
            B_AMARELO:
                if (w_done) w_next = VERM_B;
            VERM_B:
                if (w_done) w_next = r_ped_pend ? PED : A_VERDE;
            PED:
                if (w_done)
                    w_next = (r_nxt == ROAD_A) ? A_VERDE : B_VERDE;
            default:
                w_next = A_VERDE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= A_VERDE;
            r_nxt      <= ROAD_B;
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
            r_ped_pend <= 1'b0;
            r_a        <= LAMP_VERDE;
            r_b        <= LAMP_VERMELHO;
            r_walk     <= 1'b0;
        end else begin
            r_state      <= w_next;
            {r_a, r_b}   <= lamps(w_next);
            r_walk       <= (w_next == PED);
            if (r_state == VERM_A && w_chg) r_nxt <= ROAD_B;
            if (r_state == VERM_B && w_chg) r_nxt <= ROAD_A;
            // Entry into the serving phase wins over a same-edge set.
            if (w_next == A_VERDE && r_state != A_VERDE)
                r_pend_a <= 1'b0;
            else if (bus.req_a && r_state != A_VERDE)
                r_pend_a <= 1'b1;
            if (w_next == B_VERDE && r_state != B_VERDE)
                r_pend_b <= 1'b0;
            else if (bus.req_b && r_state != B_VERDE)
                r_pend_b <= 1'b1;
            if (w_next == PED && r_state != PED)
                r_ped_pend <= 1'b0;
            else if (bus.bt && r_state != PED)
                r_ped_pend <= 1'b1;
        end
    end

    assign bus.A        = r_a;
    assign bus.B        = r_b;
    assign bus.ped_walk = r_walk;
endmodule

// File: tb/tb_semaforo_escalonador.sv
// Scoreboard bench: stimulus queues hand-derived lamp phases per cycle,
// a negedge monitor pops and compares them against the heads.
module tb_semaforo_escalonador;
    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       w;
        int         t;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    semaforo_escalonador_if bus ();

    semaforo_escalonador dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Phase letter per test/cycle, taken from the timing walkthroughs.
    // a/y: A verde/amarelo, b/z: B verde/amarelo, r: all red, p: walk.
    function automatic logic [7:0] phase(int t, int c);
        case (t)
            1: begin
                if (c <= 2) return "a";
                if (c == 3) return "y";
                if (c <= 5) return "r";
                return "b";
            end
            2: begin
                if (c <= 7) return "a";
                if (c == 8) return "y";
                if (c <= 10) return "r";
                if (c <= 13) return "b";
                if (c == 14) return "z";
                if (c <= 16) return "r";
                return "a";
            end
            3, 4: begin
                if (c <= 2) return "a";
                if (c == 3) return "y";
                if (c <= 5) return "r";
                if (c <= 9) return "p";
                return "b";
            end
            5: begin
                if (c <= 2) return "a";
                if (c == 3) return "y";
                if (c <= 5) return "r";
                if (c <= 7) return "p";
                if (c <= 10) return "a";
                if (c == 11) return "y";
                if (c <= 13) return "r";
                return "b";
            end
            default: return "a";
        endcase
    endfunction

    task automatic push(int t, int c);
        exp_t e;
        e.t = t;
        e.c = c;
        e.w = 1'b0;
        e.a = 3'b100;
        e.b = 3'b100;
        case (phase(t, c))
            "a": e.a = 3'b001;
            "y": e.a = 3'b010;
            "b": e.b = 3'b001;
            "z": e.b = 3'b010;
            "p": e.w = 1'b1;
            default: ;
        endcase
        q.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (bus.A !== e.a || bus.B !== e.b
                || bus.ped_walk !== e.w) begin
                fails++;
                $display("FAIL lamps t%0d c%0d: got A=%b B=%b walk=%b, want A=%b B=%b walk=%b",
                         e.t, e.c, bus.A, bus.B, bus.ped_walk,
                         e.a, e.b, e.w);
            end
            tests++;
            if ($countones(bus.A) != 1 || $countones(bus.B) != 1
                || (bus.A != 3'b100 && bus.B != 3'b100)
                || (bus.ped_walk && (bus.A != 3'b100
                                     || bus.B != 3'b100))) begin
                fails++;
                $display("FAIL safety t%0d c%0d: got A=%b B=%b walk=%b, want one-hot, one head red, walk only all-red",
                         e.t, e.c, bus.A, bus.B, bus.ped_walk);
            end
        end
    end

    int len[6] = '{20, 23, 17, 16, 16, 18};

    initial begin
        bus.bt    = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            bus.bt    = 1'b0;
            bus.req_a = 1'b0;
            bus.req_b = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            for (int c = 0; c < len[t]; c++) begin
                if (c > 0) begin
                    @(posedge clk);
                    #1;
                end
                bus.bt    = (t >= 3) && (c == 0);
                bus.req_a = (t == 2);
                bus.req_b = ((c == 0) && (t == 1 || t == 2 || t == 4))
                            || (t == 5 && c == 8);
                rst       = (t == 5) && (c == 7);
                push(t, c);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
